// File: rtl/fpu_float_round_encode.sv
// Normalize, round and pack an unpacked intermediate into an IEEE-754 single-precision word.
// One operation at a time through a four-state FSM with a valid/ready handshake on each side.
module fpu_float_round_encode (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_sign,
   input  logic [9:0]  in_exponent,
   input  logic [26:0] in_mantissa,
   input  logic        in_sticky,
   input  logic [3:0]  in_conditions,
   input  logic [1:0]  in_round_mode,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        out_inexact,
   output logic        out_overflow,
   output logic        out_underflow
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_NORM  = 2'd1;
   localparam logic [1:0] ST_ROUND = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [1:0] RM_EVEN = 2'd0;
   localparam logic [1:0] RM_DOWN = 2'd1;
   localparam logic [1:0] RM_UP   = 2'd2;
   localparam logic [1:0] RM_ZERO = 2'd3;

   localparam int unsigned COND_INF  = 3;
   localparam int unsigned COND_NAN  = 2;
   localparam int unsigned COND_ZERO = 0;

   logic [1:0]         state_q, state_d;
   logic               sign_q, sticky_q;
   logic signed [11:0] exp_q;
   logic [26:0]        mant_q;
   logic [3:0]         cond_q;
   logic [1:0]         mode_q;
   logic               out_valid_q, inexact_q, overflow_q, underflow_q;
   logic [31:0]        result_q;

   // Normalization datapath
   logic [4:0]         lz, sh_l, sh_r;
   logic               lz_found;
   logic signed [11:0] lim, diff, norm_exp;
   logic [26:0]        norm_mant, lost_mask;
   logic               norm_sticky;

   always_comb begin
      lz       = 5'd0;
      lz_found = 1'b0;
      for (int i = 25; i >= 0; i--) begin
         if (!lz_found) begin
            if (mant_q[i]) lz_found = 1'b1;
            else           lz = lz + 5'd1;
         end
      end
   end

   always_comb begin
      norm_exp    = exp_q;
      norm_mant   = mant_q;
      norm_sticky = sticky_q;
      lim         = exp_q - 12'sd1;
      sh_l        = 5'd0;
      sh_r        = 5'd0;
      diff        = 12'sd0;
      lost_mask   = '0;
      if (mant_q[26]) begin
         norm_mant   = mant_q >> 1;
         norm_sticky = sticky_q | mant_q[0];
         norm_exp    = exp_q + 12'sd1;
      end else if (!mant_q[25] && (mant_q != '0)) begin
         // Left shift stops early rather than let the exponent fall below 1.
         if (lim <= 12'sd0)                       sh_l = 5'd0;
         else if (lim < $signed({7'd0, lz}))      sh_l = lim[4:0];
         else                                     sh_l = lz;
         norm_mant = mant_q << sh_l;
         norm_exp  = exp_q - $signed({7'd0, sh_l});
      end
      if (norm_exp < 12'sd1) begin
         diff        = 12'sd1 - norm_exp;
         sh_r        = (diff > 12'sd26) ? 5'd26 : diff[4:0];
         lost_mask   = (27'd1 << sh_r) - 27'd1;
         norm_sticky = norm_sticky | (|(norm_mant & lost_mask));
         norm_mant   = norm_mant >> sh_r;
         norm_exp    = 12'sd1;
      end
   end

   // Rounding and encoding datapath
   logic               hidden, inexact, round_up, carry, ovf_max, is_zero;
   logic [24:0]        sum;
   logic signed [11:0] exp_field;
   logic [31:0]        result_d;
   logic               inexact_d, overflow_d, underflow_d;

   always_comb begin
      hidden  = mant_q[25];
      inexact = (|mant_q[1:0]) | sticky_q;
      case (mode_q)
         RM_EVEN: round_up = mant_q[1] & (mant_q[0] | sticky_q | mant_q[2]);
         RM_DOWN: round_up = sign_q & inexact;
         RM_UP:   round_up = ~sign_q & inexact;
         default: round_up = 1'b0;
      endcase
      sum       = {1'b0, hidden, mant_q[24:2]} + {24'd0, round_up};
      // Carry past the top bit (1.11..1 -> 10.0) or into the hidden bit (denormal -> normal).
      carry     = sum[24] | (~hidden & sum[23]);
      exp_field = (hidden ? exp_q : 12'sd0) + $signed({11'd0, carry});
      ovf_max   = (mode_q == RM_ZERO) | ((mode_q == RM_UP) & sign_q) |
                  ((mode_q == RM_DOWN) & ~sign_q);
      is_zero   = cond_q[COND_ZERO] | ((mant_q == '0) & ~sticky_q);

      result_d    = {sign_q, exp_field[7:0], sum[22:0]};
      inexact_d   = inexact;
      overflow_d  = 1'b0;
      underflow_d = ~hidden & inexact;
      if (exp_field >= 12'sd255) begin
         result_d   = ovf_max ? {sign_q, 31'h7F7FFFFF} : {sign_q, 8'hFF, 23'h0};
         overflow_d = 1'b1;
         inexact_d  = 1'b1;
      end
      if (cond_q[COND_NAN] | cond_q[COND_INF] | is_zero) begin
         inexact_d   = 1'b0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
         if (cond_q[COND_NAN])      result_d = 32'hFFFFFFFF;
         else if (cond_q[COND_INF]) result_d = {sign_q, 8'hFF, 23'h0};
         else                       result_d = {sign_q, 31'h0};
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (in_valid) state_d = ST_NORM;
         ST_NORM:  state_d = ST_ROUND;
         ST_ROUND: state_d = ST_DONE;
         default:  if (out_ready) state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         sign_q      <= 1'b0;
         sticky_q    <= 1'b0;
         exp_q       <= 12'sd0;
         mant_q      <= '0;
         cond_q      <= '0;
         mode_q      <= '0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         inexact_q   <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  sign_q   <= in_sign;
                  sticky_q <= in_sticky;
                  exp_q    <= {{2{in_exponent[9]}}, in_exponent};
                  mant_q   <= in_mantissa;
                  cond_q   <= in_conditions;
                  mode_q   <= in_round_mode;
               end
            end
            ST_NORM: begin
               exp_q    <= norm_exp;
               mant_q   <= norm_mant;
               sticky_q <= norm_sticky;
            end
            ST_ROUND: begin
               result_q    <= result_d;
               inexact_q   <= inexact_d;
               overflow_q  <= overflow_d;
               underflow_q <= underflow_d;
               out_valid_q <= 1'b1;
            end
            default: begin
               if (out_ready) out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready      = (state_q == ST_IDLE);
   assign out_valid     = out_valid_q;
   assign out_result    = result_q;
   assign out_inexact   = inexact_q;
   assign out_overflow  = overflow_q;
   assign out_underflow = underflow_q;

endmodule
